// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down step driver.
package updown_pkg;

  localparam int unsigned COUNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/updown_step_driver_if.sv
// Control/pulse bundle between control logic (master) and the step driver (slave).
interface updown_step_driver_if #(
  parameter int unsigned COUNT_W = 4
);
  logic               load;
  logic [COUNT_W-1:0] target;
  logic               up;
  logic               down;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count_mirror;

  modport master (output load, output target,
                  input up, input down, input busy, input done, input count_mirror);
  modport slave  (input load, input target,
                  output up, output down, output busy, output done, output count_mirror);
endinterface

// File: rtl/updown_dir_calc.sv
// Combinational direction and zero-distance decode from mirror and target.
// Macro UPDOWN_SHORTEST_PATH_EN selects modular shortest-path direction.
module updown_dir_calc
  import updown_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic [COUNT_W-1:0] mirror,
  input  logic [COUNT_W-1:0] target,
  output dir_e               dir_c,
  output logic               zero_c
);

`ifdef UPDOWN_SHORTEST_PATH_EN
  localparam logic [COUNT_W-1:0] HALF = {1'b1, {(COUNT_W-1){1'b0}}};
  logic [COUNT_W-1:0] d_up;

  // Exactly half the range resolves upward.
  always_comb begin
    d_up  = target - mirror;
    dir_c = (d_up <= HALF) ? DIR_UP : DIR_DOWN;
  end
`else
  always_comb begin
    dir_c = (target > mirror) ? DIR_UP : DIR_DOWN;
  end
`endif

  assign zero_c = (target == mirror);

endmodule

// File: rtl/updown_step_driver.sv
// Drives single-cycle up/down pulses until a mirrored downstream counter reaches a target.
// Optional macro UPDOWN_SHORTEST_PATH_EN (see updown_dir_calc) picks modular shortest direction.
module updown_step_driver
  import updown_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input logic                clk,
  input logic                n_rst,
  updown_step_driver_if.slave bus
);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  dir_e               dir_c;
  logic               zero_c;
  logic [COUNT_W-1:0] target_q, target_d;
  logic [COUNT_W-1:0] mirror_q, mirror_d;
  logic [COUNT_W-1:0] mirror_step;
  logic               up_q, up_d;
  logic               down_q, down_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  updown_dir_calc #(.COUNT_W(COUNT_W)) u_dir_calc (
    .mirror (mirror_q),
    .target (bus.target),
    .dir_c  (dir_c),
    .zero_c (zero_c)
  );

  // Mirror follows the pulse the downstream counter samples on this edge.
  assign mirror_step = mirror_q + COUNT_W'(up_q) - COUNT_W'(down_q);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    target_d = target_q;
    mirror_d = mirror_step;
    up_d     = 1'b0;
    down_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.load) begin
          target_d = bus.target;
          if (zero_c) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = STEP;
            dir_d   = dir_c;
            busy_d  = 1'b1;
            up_d    = (dir_c == DIR_UP);
            down_d  = (dir_c == DIR_DOWN);
          end
        end
      end
      STEP: begin
        if (mirror_step == target_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          up_d   = (dir_q == DIR_UP);
          down_d = (dir_q == DIR_DOWN);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      target_q <= '0;
      mirror_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      mirror_q <= mirror_d;
      up_q     <= up_d;
      down_q   <= down_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.up           = up_q;
  assign bus.down         = down_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.count_mirror = mirror_q;

endmodule

// File: tb/tb_updown_step_driver.sv
// Self-checking bench for updown_step_driver against a distance/direction reference model.
module tb_updown_step_driver;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  updown_step_driver_if #(.COUNT_W(4)) dut_if ();
  updown_step_driver #(.COUNT_W(4)) dut (.clk(clk), .n_rst(n_rst), .bus(dut_if.slave));

  // Independent model of the downstream up/down counter.
  logic [3:0] ds;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) ds <= 4'd0;
    else if (dut_if.up && !dut_if.down) ds <= ds + 4'd1;
    else if (dut_if.down && !dut_if.up) ds <= ds - 4'd1;
  end

  int tests = 0;
  int fails = 0;
  logic [3:0] model_m;

  int n_up, n_dn, done_k, bad_k, done_dirty;
  logic [3:0] fin_m, fin_ds;
  logic [3:0] trace[$];

  function automatic bit model_up(input logic [3:0] m, input logic [3:0] t);
`ifdef UPDOWN_SHORTEST_PATH_EN
    int d;
    d = (int'(t) - int'(m) + 16) % 16;
    return d <= 8;
`else
    return t > m;
`endif
  endfunction

  function automatic int model_dist(input logic [3:0] m, input logic [3:0] t);
    int d;
    d = (int'(t) - int'(m) + 16) % 16;
    if (d == 0) return 0;
    return model_up(m, t) ? d : 16 - d;
  endfunction

  function automatic bit trace_ok(input logic [3:0] m, input logic [3:0] t);
    bit ok = 1'b1;
    int v;
    for (int i = 0; i < trace.size(); i++) begin
      v = ((int'(m) + (model_up(m, t) ? i : -i)) % 16 + 16) % 16;
      if (trace[i] !== 4'(v)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Stimulus + observation only; caller is at a negedge, returns at negedge of the done cycle.
  task automatic run_move(input logic [3:0] tgt, input int glitch_k, input logic [3:0] glitch_t);
    n_up = 0; n_dn = 0; done_k = -1; bad_k = 0; done_dirty = 0;
    fin_m = 'x; fin_ds = 'x;
    trace.delete();
    dut_if.load = 1'b1;
    dut_if.target = tgt;
    @(negedge clk);
    dut_if.load = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      trace.push_back(dut_if.count_mirror);
      if (dut_if.done === 1'b1) begin
        done_k = k;
        fin_m = dut_if.count_mirror;
        fin_ds = ds;
        done_dirty = int'(dut_if.busy | dut_if.up | dut_if.down);
        break;
      end
      if (dut_if.up === dut_if.down || dut_if.busy !== 1'b1) bad_k++;
      if (dut_if.up === 1'b1) n_up++;
      if (dut_if.down === 1'b1) n_dn++;
      dut_if.load = (k == glitch_k);
      dut_if.target = (k == glitch_k) ? glitch_t : tgt;
      @(negedge clk);
    end
    dut_if.load = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({dut_if.up, dut_if.down, dut_if.busy, dut_if.done} !== 4'b0 || dut_if.count_mirror !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: got up/down/busy/done=%b mirror=%0d, want 0000 mirror=0",
               {dut_if.up, dut_if.down, dut_if.busy, dut_if.done}, dut_if.count_mirror);
    end
  endtask

  task automatic test_up_run;
    run_move(4'd5, 0, 4'd0);
    tests++; if (n_up !== 5 || n_dn !== 0) begin fails++; $display("FAIL up_run_pulses: got up=%0d down=%0d, want 5/0", n_up, n_dn); end
    tests++; if (done_k !== 6) begin fails++; $display("FAIL up_run_done_cycle: got %0d, want 6", done_k); end
    tests++; if (fin_m !== 4'd5 || fin_ds !== 4'd5) begin fails++; $display("FAIL up_run_final: got mirror=%0d ds=%0d, want 5", fin_m, fin_ds); end
    tests++; if (bad_k !== 0 || done_dirty !== 0) begin fails++; $display("FAIL up_run_shape: got bad=%0d dirty=%0d, want 0/0", bad_k, done_dirty); end
    @(negedge clk);
    tests++; if (dut_if.done !== 1'b0 || dut_if.busy !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got done=%b busy=%b, want 0/0", dut_if.done, dut_if.busy); end
    model_m = 4'd5;
  endtask

  task automatic test_down_run;
    run_move(4'd2, 0, 4'd0);
    tests++; if (n_dn !== 3 || n_up !== 0) begin fails++; $display("FAIL down_run_pulses: got up=%0d down=%0d, want 0/3", n_up, n_dn); end
    tests++; if (done_k !== 4) begin fails++; $display("FAIL down_run_done_cycle: got %0d, want 4", done_k); end
    tests++; if (fin_m !== 4'd2 || fin_ds !== 4'd2) begin fails++; $display("FAIL down_run_final: got mirror=%0d ds=%0d, want 2", fin_m, fin_ds); end
    @(negedge clk);
    model_m = 4'd2;
  endtask

  task automatic test_wrap;
    run_move(4'd1, 0, 4'd0);
    @(negedge clk);
    run_move(4'd14, 0, 4'd0);
`ifdef UPDOWN_SHORTEST_PATH_EN
    tests++; if (n_dn !== 3 || n_up !== 0) begin fails++; $display("FAIL wrap_pulses: got up=%0d down=%0d, want 0/3", n_up, n_dn); end
`else
    tests++; if (n_up !== 13 || n_dn !== 0) begin fails++; $display("FAIL wrap_pulses: got up=%0d down=%0d, want 13/0", n_up, n_dn); end
`endif
    tests++; if (!trace_ok(4'd1, 4'd14)) begin fails++; $display("FAIL wrap_trace: got trace=%p, wrong step sequence from 1 to 14", trace); end
    tests++; if (fin_m !== 4'd14 || fin_ds !== 4'd14) begin fails++; $display("FAIL wrap_final: got mirror=%0d ds=%0d, want 14", fin_m, fin_ds); end
    @(negedge clk);
    model_m = 4'd14;
  endtask

  task automatic test_zero;
    run_move(4'd7, 0, 4'd0);
    @(negedge clk);
    run_move(4'd7, 0, 4'd0);
    tests++; if (done_k !== 1 || n_up + n_dn !== 0) begin fails++; $display("FAIL zero_distance: got done_cycle=%0d pulses=%0d, want 1/0", done_k, n_up + n_dn); end
    tests++; if (done_dirty !== 0 || fin_m !== 4'd7) begin fails++; $display("FAIL zero_quiet: got busy/pulse=%0d mirror=%0d, want 0/7", done_dirty, fin_m); end
    @(negedge clk);
    model_m = 4'd7;
  endtask

  task automatic test_back_to_back;
    logic [3:0] t;
    run_move(4'd12, 0, 4'd0);
    @(negedge clk);
    run_move(4'd4, 3, 4'd9);
    tests++; if (done_k !== 9 || fin_m !== 4'd4 || fin_ds !== 4'd4) begin fails++; $display("FAIL ignore_load: got done_cycle=%0d mirror=%0d ds=%0d, want 9/4/4", done_k, fin_m, fin_ds); end
    t = 4'd4 ^ 4'd10;
    run_move(t, 0, 4'd0);
    tests++; if (done_k !== model_dist(4'd4, t) + 1 || bad_k !== 0) begin fails++; $display("FAIL back_to_back: got done_cycle=%0d gaps=%0d, want %0d/0", done_k, bad_k, model_dist(4'd4, t) + 1); end
    tests++; if (fin_m !== t || fin_ds !== t) begin fails++; $display("FAIL back_to_back_final: got mirror=%0d ds=%0d, want %0d", fin_m, fin_ds, t); end
    model_m = t;
  endtask

  task automatic test_random;
    logic [3:0] t, g;
    int d, gk;
    bit u;
    for (int i = 0; i < 30; i++) begin
      t = 4'($urandom_range(0, 15));
      g = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      d = model_dist(model_m, t);
      u = model_up(model_m, t);
      gk = (d > 3) ? int'($urandom_range(1, 3)) : 0;
      run_move(t, gk, g);
      tests++;
      if (done_k !== d + 1 || n_up !== (u ? d : 0) || n_dn !== (u ? 0 : d) || bad_k !== 0 || done_dirty !== 0) begin
        fails++;
        $display("FAIL random_run[%0d] %0d->%0d: got done=%0d up=%0d dn=%0d bad=%0d dirty=%0d, want done=%0d up=%0d dn=%0d",
                 i, model_m, t, done_k, n_up, n_dn, bad_k, done_dirty, d + 1, u ? d : 0, u ? 0 : d);
      end
      tests++;
      if (fin_m !== t || fin_ds !== t || !trace_ok(model_m, t)) begin
        fails++;
        $display("FAIL random_mirror[%0d]: got mirror=%0d ds=%0d trace=%p, want %0d", i, fin_m, fin_ds, trace, t);
      end
      model_m = t;
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    dut_if.load = 1'b1;
    dut_if.target = 4'd8;
    @(negedge clk);
    dut_if.load = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dut_if.count_mirror !== 4'd3 || dut_if.up !== 1'b1) begin fails++; $display("FAIL pre_reset_step: got mirror=%0d up=%b, want 3/1", dut_if.count_mirror, dut_if.up); end
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({dut_if.up, dut_if.down, dut_if.busy, dut_if.done} !== 4'b0 || dut_if.count_mirror !== 4'd0 || ds !== 4'd0) begin
      fails++;
      $display("FAIL async_reset: got up/down/busy/done=%b mirror=%0d ds=%0d, want 0000/0/0",
               {dut_if.up, dut_if.down, dut_if.busy, dut_if.done}, dut_if.count_mirror, ds);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({dut_if.up, dut_if.down, dut_if.busy, dut_if.done} !== 4'b0 || dut_if.count_mirror !== 4'd0) begin
      fails++;
      $display("FAIL reset_idle: got up/down/busy/done=%b mirror=%0d, want 0000/0",
               {dut_if.up, dut_if.down, dut_if.busy, dut_if.done}, dut_if.count_mirror);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    dut_if.load = 1'b0;
    dut_if.target = 4'd0;
    model_m = 4'd0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_up_run();
    test_down_run();
    test_wrap();
    test_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_step_driver.md
# updown_step_driver

Transmitter end of the up/down count interface. Accepts a 4-bit target value and drives a stream of single-cycle `up` / `down` pulses until a downstream up/down counter reaches that value. It keeps an internal mirror of the downstream count. It sits between co-processor control logic and any up/down-counted resource (occupancy or exponent-step counters), so control can set an absolute value through an increment-only interface.

## Interface
Parameters:
- COUNT_W, 4, width of target and mirrored count; downstream counter wraps modulo 2^COUNT_W.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- load  input  1  request to move the counter to `target`; sampled on rising edge.
- target  input  COUNT_W  requested count value; sampled when `load` is accepted.
- up  output  1  registered increment pulse to the downstream counter.
- down  output  1  registered decrement pulse to the downstream counter.
- busy  output  1  high while stepping; `load` is ignored while high.
- done  output  1  one-cycle pulse when the mirror equals the latched target.
- count_mirror  output  COUNT_W  value the downstream counter holds after the current edge.

## Operation
- Downstream semantics being mirrored:
  - `up` alone: +1 mod 2^COUNT_W.
  - `down` alone: −1 mod 2^COUNT_W.
  - Both or neither: hold.
- `up` and `down` are never asserted together.
- FSM states: IDLE, STEP, DONE.
  - IDLE/DONE + `load`: latch `target`.
    - If target == count_mirror, go to DONE.
    - Otherwise compute direction and go to STEP.
  - STEP: assert exactly one of `up`/`down` every cycle.
    - count_mirror steps by ±1 on the same edge the downstream counter samples the pulse.
    - When the next mirror value equals target, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE. `load` in DONE is accepted as in IDLE; `done` still pulses that cycle.
  - STEP + `load`: ignored; no retargeting.
- Direction is fixed at load time and does not change during a STEP run.
- Mirror arithmetic is modulo 2^COUNT_W. Wrap-around is legal only when the configured direction rule produces it.
- Reset (asynchronous, any state):
  - state=IDLE.
  - up=down=busy=done=0.
  - count_mirror=0.
  - latched target=0.
- The block assumes the downstream counter shares clk/n_rst and is driven only by this block.

## Timing
- `load` sampled at edge E0.
- Distance N>0:
  - busy=1 and one pulse per cycle in cycles 1..N.
  - count_mirror reaches target at edge EN.
  - done=1 in cycle N+1; busy=0 from cycle N+1.
- Distance 0: no pulses, busy stays 0, done=1 in cycle 1.
- Throughput: a new `load` accepted in the DONE cycle starts pulsing the following cycle. No idle gap is required.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- Macro `UPDOWN_SHORTEST_PATH_EN`.
- Defined:
  - Direction minimises steps modulo 2^COUNT_W.
  - d_up = (target − mirror) mod 2^COUNT_W. Use `up` if d_up ≤ 2^(COUNT_W−1), otherwise `down`.
  - Tie at exactly half the range goes up.
  - Wrap through 0 / max is expected.
- Undefined:
  - Linear direction: `up` if target > mirror (unsigned), `down` if target < mirror.
  - Never wraps.

## Structure
- Package `updown_pkg`:
  - state enum (IDLE, STEP, DONE).
  - default COUNT_W constant.
  - direction encoding type (DIR_UP, DIR_DOWN).
- Sub-module `updown_dir_calc` (combinational): from mirror, target and the macro, produce the direction and the zero-distance flag.
- Top level holds the FSM, target register, mirror counter and output registers.

## Test plan
- Reset: assert n_rst=0 mid-STEP (mirror=3, up=1) → up, down, busy, done and count_mirror all go to 0 immediately, before the next clk edge; FSM returns to IDLE.
- From mirror 0, load target=5 → up=1 in cycles 1–5, down=0 throughout, done in cycle 6, mirror=5; downstream counter model also reads 5.
- From mirror 5, load target=2 → down=1 in cycles 1–3, done in cycle 4, mirror=2.
- From mirror 1, load target=14:
  - With macro: down pulses ×3, mirror 0, 15, 14.
  - Without macro: up pulses ×13, no wrap.
- Load target equal to mirror (7) → zero pulses, busy stays 0, done in cycle 1.
- Load target=9 during a STEP run toward 4 → ignored; run ends at 4. A back-to-back load in the DONE cycle starts pulsing the next cycle.
